// File: rtl/rst_seq_gen.sv
// ============================================================================
// Module   : rst_seq_gen
// Purpose  : Multi-channel reset sequencer. The board reset asserts every
//            channel asynchronously. Its release is synchronised and then
//            held for P_HOLD_CYCLE cycles. After that, the channels are
//            released one at a time, P_STAGGER_CYCLE cycles apart, with
//            bit 0 first. A soft-reset request restarts the sequence.
// Ports    : i_clk      - system clock
//            i_rst_n    - asynchronous active-low board reset
//            i_soft_rst - synchronous soft-reset request (active high)
//            i_hold     - freezes the sequence counters while high
//            o_rst      - active-high channel resets (registered)
//            o_stage    - number of channels currently released
//            o_done     - high once every channel is released
// Options  : define UART_RST_SOFT_DEB_EN to require the soft-reset request
//            to be high for P_DEB_CYCLE consecutive edges before it acts.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rst_seq_gen #(
  parameter int P_CHANNELS      = 4,
  parameter int P_HOLD_CYCLE    = 16,
  parameter int P_STAGGER_CYCLE = 8,
  parameter int P_SYNC_STAGES   = 2,
  parameter int P_DEB_CYCLE     = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_soft_rst,
  input  logic                              i_hold,
  output logic [P_CHANNELS-1:0]             o_rst,
  output logic [$clog2(P_CHANNELS+1)-1:0]   o_stage,
  output logic                              o_done
);

  localparam int MAX_CNT = (P_HOLD_CYCLE > P_STAGGER_CYCLE) ? P_HOLD_CYCLE : P_STAGGER_CYCLE;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam int SW      = $clog2(P_CHANNELS + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'((P_HOLD_CYCLE > 0) ? P_HOLD_CYCLE - 1 : 0);
  localparam logic [CW-1:0] STAG_LAST  = CW'((P_STAGGER_CYCLE > 0) ? P_STAGGER_CYCLE - 1 : 0);
  localparam logic [SW-1:0] LAST_STAGE = SW'(P_CHANNELS - 1);
  localparam logic [SW-1:0] ALL_STAGE  = SW'(P_CHANNELS);
  // With a single channel or no stagger, the first release is also the last.
  localparam bit RELEASE_ALL = (P_CHANNELS == 1) || (P_STAGGER_CYCLE == 0);

  // Elaboration-time legality checks on the parameter set.
  if ((P_CHANNELS < 1) || (P_CHANNELS > 16) || (P_SYNC_STAGES < 2) ||
      (P_DEB_CYCLE < 1) || (P_HOLD_CYCLE < 0) || (P_STAGGER_CYCLE < 0)) begin : g_param_check
    $error("rst_seq_gen: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [P_SYNC_STAGES-1:0] sync;
  logic                     soft_req;
  logic                     hold_en;
  logic                     run_en;

  // Deassertion synchroniser: clears asynchronously, fills with ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[P_SYNC_STAGES-2:0], 1'b1};
    end
  end

  // The hold count starts on the edge after the chain output rises, so the
  // first release lands P_HOLD_CYCLE edges after that rise. With no hold
  // time, the release has to coincide with the rising edge itself. That is
  // why the FSM then keys off the stage feeding the chain output.
  assign hold_en = (P_HOLD_CYCLE == 0) ? sync[P_SYNC_STAGES-2] : sync[P_SYNC_STAGES-1];

`ifdef UART_RST_SOFT_DEB_EN
  localparam int             DW       = (P_DEB_CYCLE > 1) ? $clog2(P_DEB_CYCLE) : 1;
  localparam logic [DW-1:0]  DEB_LAST = DW'(P_DEB_CYCLE - 1);
  logic [DW-1:0]             deb_cnt;

  // deb_cnt counts the consecutive high samples before the current edge.
  // It saturates at DEB_LAST, so a long request stays effective.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      deb_cnt <= '0;
    end else if (!i_soft_rst) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_LAST) begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  assign soft_req = i_soft_rst && (deb_cnt == DEB_LAST);
`else
  assign soft_req = i_soft_rst;
`endif

  // i_hold freezes the counting states only. Soft reset is handled first.
  assign run_en = !i_hold || (state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_ASSERT;
      cnt     <= '0;
      o_rst   <= '1;
      o_stage <= '0;
      o_done  <= 1'b0;
    end else if (soft_req) begin
      state   <= S_ASSERT;
      cnt     <= '0;
      o_rst   <= '1;
      o_stage <= '0;
      o_done  <= 1'b0;
    end else if (run_en) begin
      case (state)
        S_ASSERT: begin
          if (hold_en) begin
            if ((P_HOLD_CYCLE == 0) || (cnt == HOLD_LAST)) begin
              cnt <= '0;
              if (RELEASE_ALL) begin
                o_rst   <= '0;
                o_stage <= ALL_STAGE;
                o_done  <= 1'b1;
                state   <= S_DONE;
              end else begin
                o_rst   <= o_rst << 1;
                o_stage <= SW'(1);
                state   <= S_RELEASE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_RELEASE: begin
          if (cnt == STAG_LAST) begin
            // Shifting in a zero clears the lowest still-asserted channel.
            cnt     <= '0;
            o_rst   <= o_rst << 1;
            o_stage <= o_stage + SW'(1);
            if (o_stage == LAST_STAGE) begin
              o_done <= 1'b1;
              state  <= S_DONE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          // Terminal state: counters and outputs stay put.
        end
        default: begin
          state <= S_ASSERT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
